i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
- Command-level front end for the byte-level I2C master in the same clock domain. It drives the master's enable/addr/rw/wr_byte inputs and consumes its busy/rd_byte/ack_error outputs.
- Turns one register-access command (device address, 8-bit register address, 1..MAX_LEN data bytes, read or write) into the correct busy-edge-paced byte sequence, including the repeated start for reads.
- Returns read data, a done pulse and error flags to the system side.

Parameters:
- MAX_LEN, 4: maximum bytes per command; data buses are 8*MAX_LEN wide.
- TIMEOUT_CYCLES, 16384: idle-busy cycles before abort.

Ports:
- i_clk  in  1  system clock; same clock as the I2C master.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE; a command is accepted when valid && ready.
- i_cmd_rw  in  1  0 = register write, 1 = register read.
- i_cmd_dev_addr  in  7  slave address.
- i_cmd_reg_addr  in  8  register address.
- i_cmd_len  in  $clog2(MAX_LEN)+1  byte count, 1..MAX_LEN.
- i_cmd_wr_data  in  8*MAX_LEN  byte k = bits [8k+7:8k]; byte 0 is sent first.
- o_rd_data  out  8*MAX_LEN  read bytes, same packing; unread bytes are 0.
- o_done  out  1  one-cycle pulse at command end.
- o_ack_err  out  1  valid with o_done.
- o_timeout  out  1  valid with o_done.
- o_m_enable  out  1  to master enable.
- o_m_slave_addr  out  7  to master slave address.
- o_m_rw  out  1  to master rw.
- o_m_wr_byte  out  8  to master write byte.
- i_m_busy  in  1  from master busy.
- i_m_rd_byte  in  8  from master read byte.
- i_m_ack_error  in  1  from master ack error.

Behaviour:
- Reset (i_rst_n low at a clock edge), including mid-command:
  - State goes to IDLE.
  - o_m_enable=0, o_m_rw=0, o_m_slave_addr=0, o_m_wr_byte=0.
  - o_rd_data=0, o_done=0, o_ack_err=0, o_timeout=0; all counters 0.
  - No further master handshake is attempted.
- Edge detection: busy_q <= i_m_busy; rise = i_m_busy & ~busy_q; fall = ~i_m_busy & busy_q. All outputs are registered.
- Command capture:
  - On accept, all cmd fields are latched; o_rd_data is cleared; the err/timeout flags are cleared.
  - i_cmd_len of 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- States: IDLE, REG, WDATA, RSTART, RDATA, DRAIN, DONE.
- IDLE:
  - o_cmd_ready=1.
  - On accept: o_m_enable=1, addr=dev, rw=0, wr_byte=reg_addr; go to REG the next cycle.
- REG:
  - On rise (master has latched addr+reg):
    - Write command: present wr byte 0, set idx=1, go to WDATA.
    - Read command: set o_m_rw=1 (forces a repeated start), go to RSTART.
- WDATA, on each rise:
  - If idx<len: present byte idx, idx++.
  - Otherwise: o_m_enable=0, go to DRAIN.
- RSTART, on rise (master has latched the read):
  - req=1, rx=0.
  - If len==1: o_m_enable=0.
  - Go to RDATA.
- RDATA:
  - On rise: req++; when req+1==len, o_m_enable=0.
  - On fall: store i_m_rd_byte into byte rx, then rx++.
  - When rx reaches len: go to DONE.
- DRAIN: on fall, go to DONE.
- DONE:
  - o_done=1 for exactly one cycle.
  - o_ack_err = OR of i_m_ack_error sampled every cycle from REG onward.
  - Return to IDLE; o_cmd_ready=1 the following cycle.
- Timeout:
  - A counter runs in every state except IDLE/DONE and is reset on any busy edge.
  - When it reaches TIMEOUT_CYCLES: o_m_enable=0, o_timeout=1, go to DONE. o_rd_data holds whatever bytes were captured.
- Simultaneous rise and fall cannot occur (single-bit input).
- A new i_cmd_valid during a busy command is ignored until IDLE.

Test Plan:
- Write dev=0x50, reg=0x10, len=1, data=0xA5:
  - Master sees enable rise with {0x50,0} and wr_byte 0x10.
  - wr_byte becomes 0xA5 after the 1st busy rise; enable drops after the 2nd rise.
  - o_done pulses once after busy falls; ack_err=0, timeout=0.
- Write len=4, data=0x44332211:
  - Bytes 0x10, 0x11, 0x22, 0x33, 0x44 go to the master in order, each after one busy rise.
  - Enable drops after the 5th rise; a single o_done.
- Read dev=0x68, reg=0x75, len=2, with the slave model returning 0x71, 0x3C:
  - rw goes 1 after the 1st rise.
  - Enable drops after the 3rd rise.
  - o_rd_data=0x3C71 at o_done.
- Slave NACKs the address:
  - i_m_ack_error goes 1 mid-command.
  - Command still completes; o_done with o_ack_err=1.
  - The next command reports o_ack_err=0 when the master ack_error is clear.
- Busy is stuck low after accept, with TIMEOUT_CYCLES=64:
  - Enable drops, and o_done + o_timeout pulse 64 cycles later (±1).
- i_rst_n is pulled low for 1 cycle in the middle of RDATA:
  - The next cycle shows all outputs at their reset values and o_cmd_ready=1.
  - A following read completes correctly.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Purpose: register-level command sequencer in front of a byte-level I2C master (write: addr+reg+data; read: addr+reg, repeated start, data).
// Latency: master enable asserts the cycle after accept; each further byte is presented one cycle after a master busy rise; o_done pulses for one cycle at the end.
// Backpressure: o_cmd_ready is high only while idle; i_cmd_valid is ignored during a command; a stalled master is aborted after TIMEOUT_CYCLES cycles without a busy edge.
// Ports: i_cmd_* command in / o_cmd_ready; o_rd_data, o_done, o_ack_err, o_timeout results; o_m_* / i_m_* master handshake.
module i2c_reg_sequencer #(
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_rw,
    input  logic [6:0]                 i_cmd_dev_addr,
    input  logic [7:0]                 i_cmd_reg_addr,
    input  logic [$clog2(MAX_LEN):0]   i_cmd_len,
    input  logic [8*MAX_LEN-1:0]       i_cmd_wr_data,
    output logic [8*MAX_LEN-1:0]       o_rd_data,
    output logic                       o_done,
    output logic                       o_ack_err,
    output logic                       o_timeout,
    output logic                       o_m_enable,
    output logic [6:0]                 o_m_slave_addr,
    output logic                       o_m_rw,
    output logic [7:0]                 o_m_wr_byte,
    input  logic                       i_m_busy,
    input  logic [7:0]                 i_m_rd_byte,
    input  logic                       i_m_ack_error
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REG, S_WDATA, S_RSTART, S_RDATA, S_DRAIN, S_DONE
    } state_t;

    state_t               state;
    logic                 busy_q;
    logic                 cmd_rw;
    logic [LW-1:0]        len;
    logic [8*MAX_LEN-1:0] wr_data;
    logic [LW-1:0]        idx;
    logic [LW-1:0]        req;
    logic [LW-1:0]        rx;
    logic [TW-1:0]        tcnt;
    logic                 ack_acc;

    logic                 rise;
    logic                 fall;
    logic                 active;
    logic [LW-1:0]        len_eff;
    logic [7:0]           wr_sel;

    assign rise   = i_m_busy & ~busy_q;
    assign fall   = ~i_m_busy & busy_q;
    // Watchdog and ack accumulation run only while a transfer is in flight.
    assign active = (state != S_IDLE) && (state != S_DONE);

    // Out-of-range lengths: 0 behaves as 1, anything above MAX_LEN is clamped.
    always_comb begin
        len_eff = i_cmd_len;
        if (i_cmd_len == '0)
            len_eff = LW'(1);
        else if (i_cmd_len > LW'(MAX_LEN))
            len_eff = LW'(MAX_LEN);
    end

    always_comb begin
        wr_sel = 8'h00;
        for (int k = 0; k < MAX_LEN; k++)
            if (idx == LW'(k))
                wr_sel = wr_data[8*k +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            busy_q         <= 1'b0;
            cmd_rw         <= 1'b0;
            len            <= '0;
            wr_data        <= '0;
            idx            <= '0;
            req            <= '0;
            rx             <= '0;
            tcnt           <= '0;
            ack_acc        <= 1'b0;
            o_cmd_ready    <= 1'b1;
            o_rd_data      <= '0;
            o_done         <= 1'b0;
            o_ack_err      <= 1'b0;
            o_timeout      <= 1'b0;
            o_m_enable     <= 1'b0;
            o_m_slave_addr <= 7'd0;
            o_m_rw         <= 1'b0;
            o_m_wr_byte    <= 8'd0;
        end else begin
            busy_q <= i_m_busy;
            o_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        cmd_rw         <= i_cmd_rw;
                        len            <= len_eff;
                        wr_data        <= i_cmd_wr_data;
                        idx            <= '0;
                        req            <= '0;
                        rx             <= '0;
                        tcnt           <= '0;
                        ack_acc        <= 1'b0;
                        o_rd_data      <= '0;
                        o_ack_err      <= 1'b0;
                        o_timeout      <= 1'b0;
                        o_cmd_ready    <= 1'b0;
                        // First master byte is always the register address, as a write.
                        o_m_enable     <= 1'b1;
                        o_m_slave_addr <= i_cmd_dev_addr;
                        o_m_rw         <= 1'b0;
                        o_m_wr_byte    <= i_cmd_reg_addr;
                        state          <= S_REG;
                    end
                end
                S_REG: begin
                    if (rise) begin
                        if (cmd_rw) begin
                            // Flipping rw makes the master issue a repeated start.
                            o_m_rw <= 1'b1;
                            state  <= S_RSTART;
                        end else begin
                            o_m_wr_byte <= wr_data[7:0];
                            idx         <= LW'(1);
                            state       <= S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        if (idx < len) begin
                            o_m_wr_byte <= wr_sel;
                            idx         <= idx + LW'(1);
                        end else begin
                            o_m_enable <= 1'b0;
                            state      <= S_DRAIN;
                        end
                    end
                end
                S_RSTART: begin
                    if (rise) begin
                        req <= LW'(1);
                        rx  <= '0;
                        if (len == LW'(1))
                            o_m_enable <= 1'b0;
                        state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // Each rise is the master latching one more read; drop enable
                    // once the last one has been requested so it NACKs and stops.
                    if (rise) begin
                        req <= req + LW'(1);
                        if (req + LW'(1) == len)
                            o_m_enable <= 1'b0;
                    end
                    if (fall) begin
                        for (int k = 0; k < MAX_LEN; k++)
                            if (rx == LW'(k))
                                o_rd_data[8*k +: 8] <= i_m_rd_byte;
                        rx <= rx + LW'(1);
                        if (rx + LW'(1) == len) begin
                            o_done    <= 1'b1;
                            o_ack_err <= ack_acc | i_m_ack_error;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fall) begin
                        o_done    <= 1'b1;
                        o_ack_err <= ack_acc | i_m_ack_error;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_cmd_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog: only fires on a cycle with no busy edge, so it never
            // races the per-state edge handling above.
            if (active) begin
                ack_acc <= ack_acc | i_m_ack_error;
                if (rise || fall) begin
                    tcnt <= '0;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    o_m_enable <= 1'b0;
                    o_timeout  <= 1'b1;
                    o_done     <= 1'b1;
                    o_ack_err  <= ack_acc | i_m_ack_error;
                    state      <= S_DONE;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
module tb_i2c_reg_sequencer;

    localparam int MAX_LEN = 4;
    localparam int TMO     = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_wr_data;
    logic [31:0] rd_data;
    logic        done;
    logic        ack_err;
    logic        timeout;
    logic        m_enable;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wr;
    logic        m_busy;
    logic [7:0]  m_rd_byte;
    logic        m_ack;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_rw       (cmd_rw),
        .i_cmd_dev_addr (cmd_dev),
        .i_cmd_reg_addr (cmd_reg),
        .i_cmd_len      (cmd_len),
        .i_cmd_wr_data  (cmd_wr_data),
        .o_rd_data      (rd_data),
        .o_done         (done),
        .o_ack_err      (ack_err),
        .o_timeout      (timeout),
        .o_m_enable     (m_enable),
        .o_m_slave_addr (m_addr),
        .o_m_rw         (m_rw),
        .o_m_wr_byte    (m_wr),
        .i_m_busy       (m_busy),
        .i_m_rd_byte    (m_rd_byte),
        .i_m_ack_error  (m_ack)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural byte-level master: each busy high period latches {addr,rw,byte};
    // a read byte appears on rd_byte when busy falls; keeps going while enable is high.
    logic [15:0] lat_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  force_q[$];
    bit          dead = 1'b0;
    int          mst;
    int          mcnt;
    logic        cur_rw;

    initial begin
        m_busy = 1'b0; m_rd_byte = 8'h00; mst = 0; mcnt = 0; cur_rw = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                m_busy = 1'b0;
                mst    = 0;
            end else begin
                case (mst)
                    0: if (m_enable === 1'b1 && !dead) begin
                        mst  = 3;
                        mcnt = $urandom_range(1, 3);
                    end
                    2: if (mcnt == 0) begin
                        m_busy = 1'b0;
                        if (force_q.size() > 0) m_rd_byte = force_q.pop_front();
                        else                    m_rd_byte = 8'($urandom);
                        if (cur_rw) rd_q.push_back(m_rd_byte);
                        mst  = 3;
                        mcnt = $urandom_range(1, 3);
                    end else mcnt--;
                    3: if (mcnt == 0) begin
                        if (m_enable === 1'b1) begin
                            m_busy = 1'b1;
                            cur_rw = m_rw;
                            lat_q.push_back({m_addr, m_rw, m_wr});
                            mcnt = $urandom_range(2, 5);
                            mst  = 2;
                        end else mst = 0;
                    end else mcnt--;
                    default: mst = 0;
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [2:0] len, input logic [31:0] data);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        check("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg;
        cmd_len = len; cmd_wr_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [2:0] len, input logic [31:0] data,
                           input bit nack, input bit expect_to);
        int          eff;
        int          n;
        int          d0;
        bit          seen;
        logic [31:0] exp_rd;
        logic [15:0] e;
        if (len == 0)            eff = 1;
        else if (len > MAX_LEN)  eff = MAX_LEN;
        else                     eff = int'(len);
        lat_q.delete(); rd_q.delete();
        d0 = done_cnt;
        issue(rw, dev, rg, len, data);
        check("accept_outputs", {cmd_ready, m_enable, m_addr, m_rw, m_wr},
              {1'b0, 1'b1, dev, 1'b0, rg});
        // A competing command while busy must be ignored.
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_rw = 1'($urandom); cmd_dev = 7'($urandom);
            cmd_reg = 8'($urandom); cmd_len = 3'($urandom); cmd_wr_data = $urandom;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (nack) m_ack = 1'b1;
        n = 3; seen = 1'b0;
        while (!seen && n < 3000) begin
            if (done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        check("done_seen", seen, 1'b1);
        if (expect_to) check("timeout_latency", (n >= TMO - 1 && n <= TMO + 1), 1'b1);
        check("flags", {ack_err, timeout}, {nack, expect_to});
        check("enable_off", m_enable, 1'b0);
        exp_rd = 32'h0;
        if (rw && !expect_to)
            for (int k = 0; k < eff; k++)
                if (k < rd_q.size()) exp_rd[8*k +: 8] = rd_q[k];
        check("rd_data", rd_data, exp_rd);
        @(posedge clk); #1;
        check("done_then_ready", {done, cmd_ready}, 2'b01);
        m_ack = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 1);
        if (!expect_to) begin
            check("n_latched", lat_q.size(), eff + 1);
            for (int i = 0; i < lat_q.size() && i <= eff; i++) begin
                if (i == 0) begin
                    e = {dev, 1'b0, rg};
                    check("byte_reg", lat_q[i], e);
                end else if (!rw) begin
                    e = {dev, 1'b0, data[8*(i-1) +: 8]};
                    check("byte_wr", lat_q[i], e);
                end else begin
                    check("byte_rd", lat_q[i][15:8], {dev, 1'b1});
                end
            end
            if (rw) check("n_read", rd_q.size(), eff);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'd0;
        cmd_len = 3'd0; cmd_wr_data = 32'd0; m_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {cmd_ready, m_enable, m_addr, m_rw, m_wr, done, ack_err, timeout},
              {1'b1, 20'd0});
        check("reset_rd", rd_data, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_cmd(1'b0, 7'h50, 8'h10, 3'd1, 32'h000000A5, 1'b0, 1'b0);
        run_cmd(1'b0, 7'h50, 8'h10, 3'd4, 32'h44332211, 1'b0, 1'b0);
        force_q.delete();
        force_q.push_back(8'h00); // reg-address byte slot, not a read
        force_q.push_back(8'h71);
        force_q.push_back(8'h3C);
        run_cmd(1'b1, 7'h68, 8'h75, 3'd2, 32'h0, 1'b0, 1'b0);
        check("read_3c71", rd_data, 32'h00003C71);
        force_q.delete();
        run_cmd(1'b0, 7'h22, 8'h01, 3'd2, 32'h0000BEEF, 1'b1, 1'b0);
        run_cmd(1'b0, 7'h22, 8'h01, 3'd2, 32'h0000BEEF, 1'b0, 1'b0);
        run_cmd(1'b1, 7'h11, 8'h02, 3'd0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 7'h12, 8'h03, 3'd7, 32'hCAFEF00D, 1'b0, 1'b0);

        // Randomized commands
        for (int t = 0; t < 24; t++)
            run_cmd(1'($urandom), 7'($urandom), 8'($urandom), 3'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), 1'b0);

        // Reset in the middle of a read data phase
        lat_q.delete(); rd_q.delete();
        issue(1'b1, 7'h33, 8'h44, 3'd4, 32'h0);
        n = 0;
        while (rd_q.size() < 1 && n < 500) begin @(posedge clk); #1; n++; end
        check("reached_rdata", rd_q.size() >= 1, 1'b1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("midreset_ctrl", {cmd_ready, m_enable, m_addr, m_rw, m_wr, done, ack_err, timeout},
              {1'b1, 20'd0});
        check("midreset_rd", rd_data, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        run_cmd(1'b1, 7'h68, 8'h75, 3'd3, 32'h0, 1'b0, 1'b0);

        // Master stuck: busy never rises
        dead = 1'b1;
        run_cmd(1'b0, 7'h50, 8'h10, 3'd1, 32'h000000A5, 1'b0, 1'b1);
        dead = 1'b0;
        run_cmd(1'b0, 7'h50, 8'h20, 3'd3, 32'h00C0FFEE, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
